// File: rtl/kirby_pkg.sv
// kirby_pkg: shared HID report state encoding and keycode constants for the frame-paced sprite logic.
package kirby_pkg;
    typedef enum logic [1:0] {IDLE, RSVD, KEYS, COMMIT} hid_state_t;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] HID_ROLLOVER = 8'h01;
    localparam logic [7:0] HID_FIRST_KEY = 8'h04;
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings frame_clk into the Clk domain and emits a one-cycle tick per rising edge.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);
    logic s1, s2, s3;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) {s3, s2, s1} <= 3'b000;
        else {s3, s2, s1} <= {s2, s1, frame_clk};
    end
    assign tick = s2 & ~s3;
endmodule

// File: rtl/hid_keycode_frame_latch.sv
// hid_keycode_frame_latch: parses HID boot-keyboard reports into one keycode and modifier byte,
// republished once per frame with a stuck-key timeout.
module hid_keycode_frame_latch
    import kirby_pkg::*;
#(
    parameter int REPORT_BYTES = 8,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] rpt_byte,
    input  logic       rpt_valid,
    input  logic       rpt_sop,
    output logic [7:0] keycode,
    output logic [7:0] modifiers,
    output logic       report_err,
    output logic       timeout_flag
);
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [2:0] LAST_SLOT = 3'(REPORT_BYTES - 3);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_FRAMES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_FRAMES - 1);

    hid_state_t state;
    logic tick, all_roll, fresh;
    logic [2:0] idx;
    logic [7:0] mod_buf, sel, pending_key, pending_mod;
    logic [IW-1:0] idle_frames;

    frame_tick_sync u_tick (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .tick(tick));

    // A commit coinciding with a tick is forwarded straight to the outputs.
    logic sop_byte, commit_ok, pub_fresh;
    logic [7:0] pub_key, pub_mod;
    assign sop_byte = rpt_valid & rpt_sop;
    assign commit_ok = (state == COMMIT) & ~sop_byte & ~all_roll;
    assign pub_fresh = fresh | commit_ok;
    assign pub_key = commit_ok ? sel : pending_key;
    assign pub_mod = commit_ok ? mod_buf : pending_mod;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            idx <= '0;
            mod_buf <= '0;
            sel <= '0;
            all_roll <= 1'b0;
            pending_key <= '0;
            pending_mod <= '0;
            fresh <= 1'b0;
            idle_frames <= '0;
            keycode <= '0;
            modifiers <= '0;
            report_err <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            report_err <= 1'b0;
            if (sop_byte) begin
                report_err <= state != IDLE;
                mod_buf <= rpt_byte;
                state <= RSVD;
            end else begin
                case (state)
                    IDLE: ;
                    RSVD: if (rpt_valid) begin
                        state <= KEYS;
                        idx <= '0;
                        sel <= '0;
                        all_roll <= 1'b1;
                    end
                    KEYS: if (rpt_valid) begin
                        if (sel == 8'h00 && rpt_byte >= HID_FIRST_KEY) sel <= rpt_byte;
                        all_roll <= all_roll & (rpt_byte == HID_ROLLOVER);
                        idx <= idx + 3'd1;
                        if (idx == LAST_SLOT) state <= COMMIT;
                    end
                    COMMIT: begin
                        report_err <= all_roll;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (tick && pub_fresh) begin
                keycode <= pub_key;
                modifiers <= pub_mod;
                pending_key <= pub_key;
                pending_mod <= pub_mod;
                fresh <= 1'b0;
                idle_frames <= '0;
                timeout_flag <= 1'b0;
            end else if (tick) begin
                if (idle_frames != IDLE_MAX) idle_frames <= idle_frames + IW'(1);
                if (idle_frames == IDLE_LAST) begin
                    keycode <= '0;
                    modifiers <= '0;
                    pending_key <= '0;
                    timeout_flag <= 1'b1;
                end
            end else if (commit_ok) begin
                pending_key <= sel;
                pending_mod <= mod_buf;
                fresh <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hid_keycode_frame_latch.sv
// tb_hid_keycode_frame_latch: directed checks of report parsing, frame publishing, errors and timeout.
module tb_hid_keycode_frame_latch;
    logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
    logic [7:0] rpt_byte = '0;
    logic rpt_valid = 1'b0, rpt_sop = 1'b0;
    logic [7:0] keycode, modifiers;
    logic report_err, timeout_flag;
    int total = 0, fails = 0;

    hid_keycode_frame_latch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .rpt_byte(rpt_byte), .rpt_valid(rpt_valid), .rpt_sop(rpt_sop),
        .keycode(keycode), .modifiers(modifiers),
        .report_err(report_err), .timeout_flag(timeout_flag)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sop);
        rpt_byte = b;
        rpt_valid = 1'b1;
        rpt_sop = sop;
        cyc();
        rpt_valid = 1'b0;
        rpt_sop = 1'b0;
    endtask

    task automatic send_bytes(input logic [63:0] r, input int n);
        for (int i = 0; i < n; i++) send_byte(r[63-8*i -: 8], i == 0);
    endtask

    task automatic send_report(input logic [63:0] r);
        send_bytes(r, 8);
        cyc();
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (3) cyc();
        frame_clk = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        #1;
        chk("rst_key", keycode, 8'h00);
        chk("rst_mod", modifiers, 8'h00);
        chk("rst_err", {7'b0, report_err}, 8'h00);
        chk("rst_to", {7'b0, timeout_flag}, 8'h00);
        repeat (3) cyc();
        Reset_n = 1'b1;
        cyc();

        // 1: single key, exact three-edge latency after the frame_clk rise
        send_report(64'h00_00_1A_00_00_00_00_00);
        repeat (2) cyc();
        chk("t1_pre_tick", keycode, 8'h00);
        frame_clk = 1'b1;
        repeat (2) cyc();
        chk("t1_edge2", keycode, 8'h00);
        cyc();
        chk("t1_edge3", keycode, 8'h1A);
        frame_clk = 1'b0;
        repeat (3) cyc();

        // 3: rollover report pulses report_err and keeps the previous key
        send_bytes(64'h00_00_01_01_01_01_01_01, 8);
        chk("t3_err_before", {7'b0, report_err}, 8'h00);
        cyc();
        chk("t3_err_pulse", {7'b0, report_err}, 8'h01);
        cyc();
        chk("t3_err_after", {7'b0, report_err}, 8'h00);
        do_tick();
        chk("t3_key_hold", keycode, 8'h1A);

        // 2: first slot holding a real key wins
        send_report(64'h02_00_00_07_04_00_00_00);
        do_tick();
        chk("t2_key", keycode, 8'h07);
        chk("t2_mod", modifiers, 8'h02);

        // 4: sop at byte 4 aborts the partial report and starts a new one
        send_bytes(64'h05_00_04_00_00_00_00_00, 4);
        send_byte(8'h00, 1'b1);
        chk("t4_err_pulse", {7'b0, report_err}, 8'h01);
        send_byte(8'h00, 1'b0);
        chk("t4_err_after", {7'b0, report_err}, 8'h00);
        send_byte(8'h16, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b0);
        cyc();
        do_tick();
        chk("t4_key", keycode, 8'h16);
        chk("t4_mod", modifiers, 8'h00);

        // 5: timeout after 30 frames without a report
        send_report(64'h01_00_04_00_00_00_00_00);
        do_tick();
        chk("t5_key", keycode, 8'h04);
        for (int i = 0; i < 29; i++) do_tick();
        chk("t5_key_29", keycode, 8'h04);
        chk("t5_to_29", {7'b0, timeout_flag}, 8'h00);
        do_tick();
        chk("t5_key_30", keycode, 8'h00);
        chk("t5_mod_30", modifiers, 8'h00);
        chk("t5_to_30", {7'b0, timeout_flag}, 8'h01);
        do_tick();
        chk("t5_to_sat", {7'b0, timeout_flag}, 8'h01);
        send_report(64'h00_00_07_00_00_00_00_00);
        chk("t5_to_pending", {7'b0, timeout_flag}, 8'h01);
        do_tick();
        chk("t5_to_clear", {7'b0, timeout_flag}, 8'h00);
        chk("t5_key_new", keycode, 8'h07);

        // 6: commit in the same cycle as tick is published by that tick
        send_report(64'h00_00_1A_00_00_00_00_00);
        do_tick();
        chk("t6_base", keycode, 8'h1A);
        send_bytes(64'h03_00_00_00_00_00_00_07, 7);
        frame_clk = 1'b1;
        cyc();
        send_byte(8'h07, 1'b0);
        chk("t6_before", keycode, 8'h1A);
        cyc();
        chk("t6_key", keycode, 8'h07);
        chk("t6_mod", modifiers, 8'h03);
        frame_clk = 1'b0;
        repeat (3) cyc();
        do_tick();
        chk("t6_hold", keycode, 8'h07);
        chk("t6_to", {7'b0, timeout_flag}, 8'h00);

        // 6b: async reset mid-report clears outputs immediately
        send_bytes(64'h02_00_16_00_00_00_00_00, 3);
        Reset_n = 1'b0;
        #1;
        chk("t6_rst_key", keycode, 8'h00);
        chk("t6_rst_mod", modifiers, 8'h00);
        repeat (2) cyc();
        Reset_n = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) send_byte(8'h16, 1'b0);
        send_report(64'h05_00_04_00_00_00_00_00);
        do_tick();
        chk("t6_post_key", keycode, 8'h04);
        chk("t6_post_mod", modifiers, 8'h05);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
